// File: rtl/weight_bank_loader.sv
// Packs a 64-bit weight stream into 72-bit kernel words and writes them round-robin across 8 banks.
// A word is on the write port one cycle after the edge that completes it; s_tready is low only outside LOAD.
module weight_bank_loader #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic [63:0]           s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [0:7]            wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [71:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  tlast_err
);
  localparam int BW = $clog2(9 * DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beats_left_q, beats_left_d;
  logic [127:0]          buf_q, buf_d;
  logic [4:0]            byte_cnt_q, byte_cnt_d;
  logic [2:0]            bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [0:7]            wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [71:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  tlast_err_q, tlast_err_d;
  logic                  pop, accept;
  logic [127:0]          rem;
  logic [4:0]            cnt_rem;

  assign s_tready  = (state_q == LOAD) && (beats_left_q != '0);
  assign accept    = s_tvalid && s_tready;
  assign pop       = byte_cnt_q >= 5'd9;
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign tlast_err = tlast_err_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    bank_d       = bank_q;
    row_d        = row_q;
    wen_d        = '0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    tlast_err_d  = tlast_err_q;
    rem          = pop ? (buf_q >> 72) : buf_q;
    cnt_rem      = pop ? (byte_cnt_q - 5'd9) : byte_cnt_q;
    buf_d        = rem;
    byte_cnt_d   = cnt_rem;

    if (pop) begin
      wen_d[bank_q] = 1'b1;
      waddr_d       = row_q;
      wdata_d       = buf_q[71:0];
      bank_d        = bank_q + 3'd1;
      if (bank_q == 3'd7)
        row_d = (row_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : row_q + ADDR_WIDTH'(1);
    end

    // New beat lands directly above whatever survives this cycle's pop.
    if (accept) begin
      buf_d        = rem | ({64'b0, s_tdata} << {cnt_rem, 3'b000});
      byte_cnt_d   = cnt_rem + 5'd8;
      beats_left_d = beats_left_q - BW'(1);
      if (s_tlast != (beats_left_q == BW'(1)))
        tlast_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tlast_err_d = 1'b0;
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = LOAD;
            row_d        = base_addr;
            bank_d       = 3'd0;
            beats_left_d = BW'(num_rows) * BW'(9);
            buf_d        = '0;
            byte_cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        if (accept && (beats_left_q == BW'(1)))
          state_d = FLUSH;
      end
      FLUSH: begin
        if (!pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      buf_q        <= '0;
      byte_cnt_q   <= '0;
      bank_q       <= '0;
      row_q        <= '0;
      wen_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      tlast_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      buf_q        <= buf_d;
      byte_cnt_q   <= byte_cnt_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      tlast_err_q  <= tlast_err_d;
    end
  end
endmodule

// File: tb/tb_weight_bank_loader.sv
// Scoreboard bench for weight_bank_loader: expected writes are queued when a load starts
// and popped as the write port fires.
module tb_weight_bank_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic [63:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [0:7]    wen;
  logic [AW-1:0] waddr;
  logic [71:0]   wdata;
  logic          busy;
  logic          done;
  logic          tlast_err;

  weight_bank_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .tlast_err(tlast_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    bank;
    logic [AW-1:0] addr;
    logic [71:0]   data;
  } wr_t;

  wr_t         sb[$];
  logic [71:0] mem [0:7][0:DEPTH-1];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic        ignore_wr = 1'b0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) n_done++;
      if (wen != 8'b0 && !ignore_wr) begin
        int  bk;
        wr_t e;
        bk = 0;
        for (int i = 0; i < 8; i++) if (wen[i]) bk = i;
        check("wen_onehot", 72'($countones(wen)), 72'd1);
        if (sb.size() == 0) begin
          check("unexpected_write", 72'd1, 72'd0);
        end else begin
          e = sb.pop_front();
          check("wr_bank", 72'(bk), 72'(e.bank));
          check("wr_addr", 72'(waddr), 72'(e.addr));
          check("wr_data", wdata, e.data);
          mem[bk][waddr] = wdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int base, input int rows);
    base_addr = AW'(base);
    num_rows  = (AW+1)'(rows);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Pushes the expected writes, streams bytes 0,1,2,... and waits for done.
  task automatic run_load(input int base, input int rows, input logic [3:0] vpat,
                          input int tl_beat, input logic exp_err);
    wr_t         e;
    logic [71:0] w;
    int          nd0;
    int          cyc;
    logic        got;
    logic        seen;
    for (int k = 0; k < 8 * rows; k++) begin
      for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'(9 * k + i);
      e.bank = 3'(k % 8);
      e.addr = AW'((base + k / 8) % DEPTH);
      e.data = w;
      sb.push_back(e);
    end
    nd0 = n_done;
    pulse_start(base, rows);
    check("busy_after_start", 72'(busy), 72'd1);
    check("tlast_err_cleared", 72'(tlast_err), 72'd0);
    cyc = 0;
    for (int b = 0; b < 9 * rows; b++) begin
      for (int i = 0; i < 8; i++) s_tdata[8*i +: 8] = 8'(8 * b + i);
      s_tlast = (b == 9 * rows - 1) || (b == tl_beat);
      got = 1'b0;
      while (!got && cyc < 300 * rows) begin
        s_tvalid = vpat[cyc % 4];
        got      = s_tvalid && s_tready;
        tick();
        cyc++;
      end
      if (!got) begin
        check("beat_timeout", 72'd1, 72'd0);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = done;
    end
    check("done_seen", 72'(seen), 72'd1);
    check("busy_at_done", 72'(busy), 72'd0);
    check("sb_drained", 72'(sb.size()), 72'd0);
    check("tlast_err", 72'(tlast_err), 72'(exp_err));
    tick();
    check("done_single", 72'(n_done - nd0), 72'd1);
    check("done_low_after", 72'(done), 72'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) tick();
    check("rst_wen", 72'(wen), 72'd0);
    check("rst_waddr", 72'(waddr), 72'd0);
    check("rst_wdata", wdata, 72'd0);
    check("rst_tready", 72'(s_tready), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_done", 72'(done), 72'd0);
    check("rst_tlast_err", 72'(tlast_err), 72'd0);
    rst = 1'b0;
    tick();

    run_load(0, 1, 4'b1111, -1, 1'b0);
    check("bank0_row0", mem[0][0], 72'h08_0706050403020100);
    check("bank1_row0", mem[1][0], 72'h11_100F0E0D0C0B0A09);
    check("bank7_row0", mem[7][0], 72'h47_464544434241403F);

    run_load(0, 1, 4'b1001, -1, 1'b0);

    run_load(15, 2, 4'b1111, -1, 1'b0);
    check("wrap_bank0_row0", mem[0][0], 72'h50_4F4E4D4C4B4A4948);
    check("wrap_bank0_row15", mem[0][15], 72'h08_0706050403020100);

    pulse_start(3, 0);
    check("zero_done", 72'(done), 72'd1);
    check("zero_tready", 72'(s_tready), 72'd0);
    check("zero_busy", 72'(busy), 72'd0);
    tick();
    check("zero_done_low", 72'(done), 72'd0);
    check("zero_tready_after", 72'(s_tready), 72'd0);

    ignore_wr = 1'b1;
    pulse_start(0, 1);
    for (int b = 0; b < 4; b++) begin
      s_tdata  = {8{8'hEE}};
      s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_wen", 72'(wen), 72'd0);
    check("midrst_busy", 72'(busy), 72'd0);
    check("midrst_tready", 72'(s_tready), 72'd0);
    tick();
    rst = 1'b0;
    tick();
    ignore_wr = 1'b0;
    sb.delete();
    run_load(0, 1, 4'b1111, -1, 1'b0);

    run_load(2, 1, 4'b1111, 2, 1'b1);
    repeat (3) tick();
    check("tlast_err_sticky", 72'(tlast_err), 72'd1);
    run_load(4, 1, 4'b1111, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/weight_bank_loader.md
Name: weight_bank_loader

Overview:
- Write-side feeder for weight_bank: converts a 64-bit weight byte stream (valid/ready, from the DDR/DMA path) into 72-bit 3x3-kernel words.
- Distributes words round-robin across the 8 banks and drives the weight_bank write port (wen[0:7], waddr, wdata).
- 9 input beats (72 bytes) fill exactly one address row across all 8 banks.
- Controlled by a start/busy/done handshake from the layer sequencer.

Parameters:
- DEPTH, 16, rows per bank; must match the weight_bank DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), width of the row address.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; samples base_addr and num_rows
- base_addr  input  ADDR_WIDTH  first row to write
- num_rows  input  ADDR_WIDTH+1  rows to fill, 0..DEPTH
- s_tdata  input  64  weight bytes; s_tdata[7:0] is the lowest stream byte
- s_tvalid  input  1  stream data valid
- s_tlast  input  1  marks the final beat of a transfer
- s_tready  output  1  loader accepts the beat
- wen  output  [0:7] x 1  per-bank write enable, at most one bit high
- waddr  output  ADDR_WIDTH  write row
- wdata  output  72  kernel word
- busy  output  1  load in progress
- done  output  1  one-cycle completion pulse
- tlast_err  output  1  sticky s_tlast framing error

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0: wen all 0, waddr 0, wdata 0, s_tready 0, busy 0, done 0, tlast_err 0.
  - Byte buffer is emptied and all counters cleared.
  - Reset mid-load discards the residual bytes and the remaining count. No partial write is issued after reset releases.
- States: IDLE, LOAD, FLUSH.
- IDLE:
  - start=1 latches base_addr and num_rows, sets beats_left = 9*num_rows, word_idx = 0, clears tlast_err, and moves to LOAD. busy goes to 1 on the next cycle.
  - If num_rows=0: go straight to IDLE, pulse done for one cycle, issue no writes, never raise s_tready.
- start while busy is ignored.
- Beat acceptance:
  - s_tready = (state==LOAD) && beats_left != 0.
  - A beat is accepted when s_tvalid && s_tready at a clock edge: its 8 bytes are appended above the buffered bytes, byte_cnt += 8, beats_left -= 1.
- Byte buffer:
  - 16 bytes; byte_cnt ranges 0..16.
  - Each cycle with registered byte_cnt >= 9, the lowest 9 bytes are popped as one word (lowest byte to wdata[7:0]) and byte_cnt -= 9.
  - byte_cnt never exceeds 16, so there is no overflow and no input stall from the buffer.
  - Pop and accept may occur on the same edge; the net change is byte_cnt += 8 - 9.
- Write mapping:
  - Word k goes to bank k mod 8, row (base_addr + k/8) mod DEPTH. The row address wraps from DEPTH-1 to 0.
  - wen, waddr and wdata are registered; wen is high for exactly one cycle per word.
- Latency: a word whose final byte is accepted at edge N is presented on the write port during the cycle after edge N+1.
- Transitions:
  - LOAD goes to FLUSH when beats_left reaches 0.
  - FLUSH finishes the remaining pops. byte_cnt always ends at 0 because 9 beats equal 8 words.
  - After the last wen cycle: done=1 for one cycle, busy=0, state returns to IDLE.
- Throughput: with s_tvalid held high, 9 beats produce 8 writes in 10 cycles.
- tlast_err:
  - Set if s_tlast=1 on any accepted beat other than the final one, or s_tlast=0 on the final beat.
  - The load continues unchanged; the flag holds until the next accepted start.

Test Plan:
- num_rows=1, base_addr=0; stream bytes 0x00..0x47 over 9 beats -> 8 single-bank writes to waddr 0:
  - bank0 wdata = 72'h08_0706050403020100
  - bank1 wdata = 72'h11_100F0E0D0C0B0A09
  - bank7 wdata = 72'h47_464544434241403F
  - Then weight_bank read of addr 0 (3-cycle read latency) returns rdata = bytes 0x47..0x00. done pulses once. tlast_err=0.
- Same stream with s_tvalid toggling 1,0,0,1 -> identical writes and data; wen never high on two banks at once; done after the 8th write.
- base_addr=15, num_rows=2, bytes 0x00..0x8F -> first 8 writes at waddr 15, next 8 at waddr 0; bank0 at row 0 receives 72'h50_4F4E4D4C4B4A4948.
- num_rows=0 -> done pulses the cycle after start; s_tready stays 0; no wen.
- Reset pulse after 4 accepted beats -> wen=0 and busy=0 immediately; a new start with num_rows=1 writes a clean row 0 with no stale bytes.
- s_tlast high on beat 3 of 9 -> tlast_err=1 and stays 1; all 8 writes still occur; the next start clears tlast_err.
